// File: rtl/unidade_controle.sv
// Multicycle control unit: latches the fetched instruction, decodes it and sequences the
// datapath enables through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, counting retired instructions.
module unidade_controle (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instru,
    output logic        load_en,
    output logic        store_en,
    output logic [1:0]  op_ula,
    output logic        operation_type,
    output logic        ula_entry,
    output logic        branch,
    output logic        sign,
    output logic        pc_en,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWriteback,
        StHalt,
        StErro
    } state_t;

    localparam logic [6:0]  OpR    = 7'b0110011;
    localparam logic [6:0]  OpI    = 7'b0010011;
    localparam logic [6:0]  OpLd   = 7'b0000011;
    localparam logic [6:0]  OpSd   = 7'b0100011;
    localparam logic [6:0]  OpBr   = 7'b1100011;
    localparam logic [31:0] Ebreak = 32'h00100073;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [15:0] count_q, count_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r, is_i, is_ld, is_sd, is_br, is_legal;
    logic [1:0] dec_op;
    logic       dec_sign, dec_entry, dec_optype;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    // Instruction decode from the latched IR only.
    always_comb begin
        is_r = (opcode == OpR) &&
               (((funct7 == 7'b0000000) &&
                 ((funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b011))) ||
                ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
        is_i = (opcode == OpI) &&
               ((funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b011));
        is_ld = (opcode == OpLd) && (funct3 == 3'b011);
        is_sd = (opcode == OpSd) && (funct3 == 3'b011);
        // Branch funct3 010/011 are unassigned.
        is_br = (opcode == OpBr) && (funct3[2:1] != 2'b01);
        is_legal = is_r || is_i || is_ld || is_sd || is_br;

        dec_op = 2'b00;
        if (is_r || is_i) begin
            if (funct3[1]) begin
                dec_op = 2'b10;
            end else if (is_r && funct7[5]) begin
                dec_op = 2'b01;
            end
        end
        if (is_br) begin
            dec_op = funct3[2] ? 2'b10 : 2'b11;
        end
        dec_sign   = ((is_r || is_i) && (funct3 == 3'b010)) ||
                     (is_br && funct3[2] && !funct3[1]);
        dec_entry  = is_r || is_br;
        dec_optype = !is_ld;
    end

    always_comb begin
        logic active;
        logic load_s;
        logic store_s;
        logic retire_s;

        state_d  = state_q;
        ir_d     = ir_q;
        count_d  = count_q;
        active   = 1'b0;
        load_s   = 1'b0;
        store_s  = 1'b0;
        retire_s = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ir_d    = instru;
                state_d = StDecode;
            end
            StDecode: begin
                active = 1'b1;
                if (ir_q == Ebreak) begin
                    state_d = StHalt;
                end else if (!is_legal) begin
                    state_d = StErro;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                active = 1'b1;
                if (is_br) begin
                    retire_s = 1'b1;
                    state_d  = StFetch;
                end else if (is_ld || is_sd) begin
                    state_d = StMem;
                end else begin
                    state_d = StWriteback;
                end
            end
            StMem: begin
                active = 1'b1;
                if (is_sd) begin
                    store_s  = 1'b1;
                    retire_s = 1'b1;
                    state_d  = StFetch;
                end else begin
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                active   = 1'b1;
                load_s   = 1'b1;
                retire_s = 1'b1;
                state_d  = StFetch;
            end
            StHalt, StErro: begin
                state_d = state_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A pending reset cancels any strobe due this cycle.
        load_en  = load_s && !reset;
        store_en = store_s && !reset;
        pc_en    = retire_s && !reset;

        if (retire_s) begin
            count_d = count_q + 16'd1;
        end

        op_ula         = active ? dec_op : 2'b00;
        sign           = active && dec_sign;
        ula_entry      = active && dec_entry;
        operation_type = active && dec_optype;
        branch         = active && is_br;

        busy    = (state_q != StIdle) && (state_q != StHalt) && (state_q != StErro);
        halted  = (state_q == StHalt);
        illegal = (state_q == StErro);
    end

    assign instr_count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ir_q    <= 32'h0;
            count_q <= 16'h0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit that drives the single-cycle load/store/ALU/branch datapath. It observes the fetched 32-bit instruction, latches it, decodes it and sequences the datapath's enables across FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. This guarantees at most one register write, one memory write and one PC advance per instruction. It also counts retired instructions and flags halt and illegal-opcode conditions.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; forces IDLE on next edge
- start  in  1  begins execution when sampled high in IDLE
- instru  in  32  instruction currently addressed by the PC
- load_en  out  1  register-bank write enable
- store_en  out  1  data-memory write enable
- op_ula  out  2  00 add, 01 sub, 10 slt, 11 equ
- operation_type  out  1  0 writeback from memory (ld), 1 from ALU
- ula_entry  out  1  0 ALU B = imm_ext, 1 ALU B = rs2
- branch  out  1  current instruction is a branch
- sign  out  1  1 signed compare, 0 unsigned
- pc_en  out  1  one-cycle PC advance/branch strobe
- busy  out  1  high in every state except IDLE, HALT, ERRO
- halted  out  1  high in HALT
- illegal  out  1  high in ERRO
- instr_count  out  16  retired-instruction counter

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, ERRO.
- IDLE: start=1 -> FETCH; else stay. start is ignored in every other state.
- FETCH: IR <= instru; -> DECODE.
- DECODE, from IR:
  - IR == 0x00100073 (ebreak) -> HALT.
  - An unsupported opcode/funct combination -> ERRO.
  - Otherwise -> EXECUTE.
- Supported instructions:
  - R-type (opcode 0110011): add, sub, slt, sltu.
  - I-type (opcode 0010011): addi, slti, sltiu.
  - ld (opcode 0000011, funct3 011).
  - sd (opcode 0100011, funct3 011).
  - Branches (opcode 1100011): beq, bne, blt, bge, bltu, bgeu. funct3 010 and 011 are illegal.
- EXECUTE:
  - branch: pc_en=1, then -> FETCH (retires).
  - ld, sd: -> MEM.
  - All others: -> WRITEBACK.
- MEM:
  - sd: store_en=1, pc_en=1, then -> FETCH (retires).
  - ld: -> WRITEBACK.
- WRITEBACK: load_en=1, pc_en=1, then -> FETCH (retires).
- HALT and ERRO hold until reset. All enables stay 0 in both.
- Decode outputs are Moore functions of state and IR. They hold their value from DECODE through the instruction's last state and are 0 in IDLE, FETCH, HALT and ERRO.
  - op_ula:
    - add, addi, ld, sd: 00.
    - sub (funct7 0100000): 01.
    - slt, slti, sltu, sltiu, blt, bge, bltu, bgeu: 10.
    - beq, bne: 11.
  - sign: 1 for slt, slti, blt, bge; 0 otherwise.
  - ula_entry: 1 for R-type and branches; 0 otherwise.
  - operation_type: 0 only for ld; 1 otherwise.
  - branch: 1 for opcode 1100011.
- Branch inversion for bne/bge/bgeu is done downstream by the datapath; this block never inverts.
- load_en, store_en and pc_en are each high for exactly one cycle per retired instruction, or 0 cycles where not applicable.
- instr_count: increments by 1 on every retiring edge and wraps 0xFFFF -> 0x0000. It does not increment for HALT or ERRO.

## Timing
- Reset: state IDLE, IR=0, instr_count=0; every output 0.
- Reset takes priority over all transitions, including mid-instruction. A store or write strobe due in that cycle is suppressed.
- Cycles from FETCH entry to retirement, counting the strobe cycle:
  - branch: 3.
  - R-type, I-type, sd: 4.
  - ld: 5.
- FETCH follows retirement directly, with no bubble.
- IR is sampled only in FETCH. Changes on instru during DECODE..WRITEBACK have no effect.
- start=1 and reset=1 on the same edge -> IDLE.

## Test plan
- Reset, start pulse, instru=0x00500093 (addi x1,x0,5):
  - FETCH, DECODE, EXECUTE, WRITEBACK.
  - load_en=pc_en=1 only in cycle 4.
  - op_ula=00, ula_entry=0, operation_type=1.
  - instr_count 0 -> 1.
- 0x402081B3 (sub x3,x1,x2): op_ula=01, ula_entry=1, load_en pulse in WRITEBACK.
- 0x00803203 (ld x4,8(x0)):
  - 5-cycle sequence through MEM.
  - operation_type=0; load_en only in WRITEBACK; store_en never.
- 0x00403823 (sd x4,16(x0)): store_en=pc_en=1 in MEM, load_en never, 4 cycles.
- 0x00209463 (bne x1,x2,8):
  - branch=1, op_ula=11, sign=0.
  - pc_en in EXECUTE, 3 cycles.
- Fault and counter cases:
  - 0x00100073 -> halted=1, busy=0, instr_count unchanged.
  - 0xFFFFFFFF -> illegal=1.
  - Reset asserted in MEM of sd -> store_en stays 0 and outputs clear next edge.
  - 65536 retirements -> instr_count wraps to 0.
